// File: rtl/ahb_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_ram_slave
//  Purpose  : AHB-Lite subordinate in front of a 1024x32 dual-port RAM with
//             WRITE/READ strobe interface (registered read data).
//             Writes: zero wait states. Reads: one wait state.
//             Unsupported transfers get the two-cycle ERROR response.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    RST        in   asynchronous active-low reset
//    HSEL       in   subordinate select
//    HADDR      in   [31:0] byte address (address phase)
//    HTRANS     in   [1:0]  IDLE/BUSY/NONSEQ/SEQ
//    HWRITE     in   1 = write
//    HSIZE      in   [2:0]  only word (3'b010) is legal
//    HWDATA     in   [31:0] write data (data phase)
//    HREADY     in   bus-level ready
//    HREADYOUT  out  this subordinate's ready
//    HRESP      out  0 = OKAY, 1 = ERROR
//    HRDATA     out  [31:0] read data (zero outside the read data phase)
//    WRITE      out  RAM write strobe
//    READ       out  RAM read strobe
//    WR_ADDR    out  [31:0] RAM write word index (zero-extended)
//    WR_DATA    out  [31:0] RAM write data (zero outside write data phase)
//    RD_ADDR    out  [31:0] RAM read word index (zero-extended)
//    RD_DATA    in   [31:0] registered RAM read data
// ============================================================================
module ahb_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        WRITE,
  output logic        READ,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_DATA,
  output logic [31:0] RD_ADDR,
  input  logic [31:0] RD_DATA
);

  localparam logic [2:0] c_S_IDLE     = 3'd0;
  localparam logic [2:0] c_S_WR_DP    = 3'd1;
  localparam logic [2:0] c_S_RD_ISSUE = 3'd2;
  localparam logic [2:0] c_S_RD_DP    = 3'd3;
  localparam logic [2:0] c_S_ERR1     = 3'd4;
  localparam logic [2:0] c_S_ERR2     = 3'd5;

  // Window size in bytes, one bit wider so MEM_WORDS*4 cannot overflow.
  localparam logic [32:0] c_SPAN_BYTES = 33'(MEM_WORDS) << 2;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_accept;
  logic [2:0]       w_decode;
  logic             w_unused;

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  assign w_off = HADDR - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];

  // Out-of-window check uses the full offset, so addresses past the top
  // never alias back onto low RAM words.
  assign w_err = (HSIZE != 3'b010)
               | (HADDR[1:0] != 2'b00)
               | (HADDR < BASE_ADDR)
               | ({1'b0, w_off} >= c_SPAN_BYTES);

  // HREADYOUT is folded in so a stalled cycle can never capture a new phase,
  // even if the interconnect's HREADY is not wired back from this port.
  assign w_accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  assign w_decode = w_err  ? c_S_ERR1 :
                    HWRITE ? c_S_WR_DP : c_S_RD_ISSUE;

  assign w_unused = &{1'b0, HTRANS[0], w_off[31:IDX_W+2], w_off[1:0]};

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = c_S_IDLE;
    case (r_state)
      c_S_IDLE,
      c_S_WR_DP,
      c_S_RD_DP,
      c_S_ERR2:     w_next = w_accept ? w_decode : c_S_IDLE;
      c_S_RD_ISSUE: w_next = c_S_RD_DP;
      c_S_ERR1:     w_next = c_S_ERR2;
      default:      w_next = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state  <= c_S_IDLE;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      r_state <= w_next;
      // Each index register only moves when a transfer of its own kind is
      // accepted, so WR_ADDR/RD_ADDR hold their last driven value.
      if (w_accept && !w_err && HWRITE) begin
        r_wr_idx <= w_idx;
      end
      if (w_accept && !w_err && !HWRITE) begin
        r_rd_idx <= w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from state; reset drives state to IDLE asynchronously,
  // so every output reaches its reset value immediately)
  // --------------------------------------------------------------------------
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    WRITE     = 1'b0;
    READ      = 1'b0;
    WR_DATA   = 32'h0;
    case (r_state)
      c_S_WR_DP: begin
        WRITE   = 1'b1;
        WR_DATA = HWDATA;
      end
      c_S_RD_ISSUE: begin
        READ      = 1'b1;
        HREADYOUT = 1'b0;
      end
      c_S_RD_DP: begin
        HRDATA = RD_DATA;
      end
      c_S_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
      end
      c_S_ERR2: begin
        HRESP = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    WR_ADDR              = 32'h0;
    RD_ADDR              = 32'h0;
    WR_ADDR[IDX_W-1:0]   = r_wr_idx;
    RD_ADDR[IDX_W-1:0]   = r_rd_idx;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_ram_slave
//  Purpose  : Directed self-checking bench for ahb_ram_slave with a small
//             1024x32 RAM model (write wins over read, registered read).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_ram_slave;

  logic        clk = 1'b0;
  logic        RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        WRITE;
  logic        READ;
  logic [31:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [31:0] RD_ADDR;
  logic [31:0] RD_DATA;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  always #5 clk = ~clk;

  // Single subordinate on the bus: HREADY is its own HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb_ram_slave dut (
    .clk       (clk),
    .RST       (RST),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .WRITE     (WRITE),
    .READ      (READ),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA)
  );

  // RAM model
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (WRITE) mem[WR_ADDR[9:0]] <= WR_DATA;
    else if (READ) RD_DATA <= mem[RD_ADDR[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic go_idle();
    addr_phase(1'b1, T_IDLE, 1'b0, 32'h0, 3'b010);
  endtask

  // Watchdog: the sequence is fixed-length, this only guards a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [31:0] err_addr [3];
  logic [2:0]  err_size [3];
  logic        err_wr   [3];
  logic [1:0]  q_trans  [3];
  logic        q_sel    [3];

  initial begin
    err_addr[0] = 32'h20;   err_size[0] = 3'b001; err_wr[0] = 1'b0;
    err_addr[1] = 32'h1000; err_size[1] = 3'b010; err_wr[1] = 1'b1;
    err_addr[2] = 32'h2;    err_size[2] = 3'b010; err_wr[2] = 1'b0;
    q_trans[0] = T_IDLE;   q_sel[0] = 1'b1;
    q_trans[1] = T_BUSY;   q_sel[1] = 1'b1;
    q_trans[2] = T_NONSEQ; q_sel[2] = 1'b0;

    // ---------------- reset values ----------------
    RST    = 1'b0;
    HWDATA = 32'h1234_5678;
    go_idle();
    #3;
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'h0, HRESP},     32'h0);
    chk("rst_hrdata",    HRDATA,             32'h0);
    chk("rst_write",     {31'h0, WRITE},     32'h0);
    chk("rst_read",      {31'h0, READ},      32'h0);
    chk("rst_wr_addr",   WR_ADDR,            32'h0);
    chk("rst_rd_addr",   RD_ADDR,            32'h0);
    chk("rst_wr_data",   WR_DATA,            32'h0);
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;

    // ---------------- write then read back ----------------
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'h10, 3'b010);
    tick();
    HWDATA = 32'hDEAD_BEEF;
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'b010);
    #1;
    chk("wr_write",     {31'h0, WRITE},     32'h1);
    chk("wr_wr_addr",   WR_ADDR,            32'h4);
    chk("wr_wr_data",   WR_DATA,            32'hDEAD_BEEF);
    chk("wr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    tick();
    go_idle();
    #1;
    chk("rdi_read",      {31'h0, READ},      32'h1);
    chk("rdi_rd_addr",   RD_ADDR,            32'h4);
    chk("rdi_hreadyout", {31'h0, HREADYOUT}, 32'h0);
    chk("rdi_write",     {31'h0, WRITE},     32'h0);
    chk("rdi_wr_data",   WR_DATA,            32'h0);
    tick();
    chk("rdd_hrdata",    HRDATA,             32'hDEAD_BEEF);
    chk("rdd_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rdd_hresp",     {31'h0, HRESP},     32'h0);
    tick();
    chk("idle_hrdata",   HRDATA,             32'h0);

    // ---------------- back-to-back writes then reads ----------------
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'h0, 3'b010);
    tick();
    for (int i = 0; i < 4; i++) begin
      HWDATA = 32'(i + 1);
      if (i < 3) addr_phase(1'b1, T_NONSEQ, 1'b1, 32'(4 * (i + 1)), 3'b010);
      else       addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h0, 3'b010);
      #1;
      chk("bw_write",     {31'h0, WRITE},     32'h1);
      chk("bw_wr_addr",   WR_ADDR,            32'(i));
      chk("bw_wr_data",   WR_DATA,            32'(i + 1));
      chk("bw_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("br_read",      {31'h0, READ},      32'h1);
      chk("br_rd_addr",   RD_ADDR,            32'(i));
      chk("br_hreadyout", {31'h0, HREADYOUT}, 32'h0);
      tick();
      if (i < 3) addr_phase(1'b1, T_NONSEQ, 1'b0, 32'(4 * (i + 1)), 3'b010);
      else       go_idle();
      #1;
      chk("br_hrdata",    HRDATA,             32'(i + 1));
      chk("br_dp_ready",  {31'h0, HREADYOUT}, 32'h1);
      chk("br_dp_read",   {31'h0, READ},      32'h0);
      tick();
    end

    // ---------------- error responses ----------------
    for (int i = 0; i < 3; i++) begin
      addr_phase(1'b1, T_NONSEQ, err_wr[i], err_addr[i], err_size[i]);
      tick();
      go_idle();
      #1;
      chk("e1_hresp",     {31'h0, HRESP},     32'h1);
      chk("e1_hreadyout", {31'h0, HREADYOUT}, 32'h0);
      chk("e1_strobes",   {30'h0, WRITE, READ}, 32'h0);
      tick();
      chk("e2_hresp",     {31'h0, HRESP},     32'h1);
      chk("e2_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("e2_strobes",   {30'h0, WRITE, READ}, 32'h0);
      tick();
      chk("e_after_hresp", {31'h0, HRESP},    32'h0);
    end

    // ---------------- IDLE / BUSY / unselected ----------------
    HWDATA = 32'hA5A5_5A5A;
    for (int i = 0; i < 3; i++) begin
      addr_phase(q_sel[i], q_trans[i], 1'b1, 32'h8, 3'b010);
      tick();
      chk("q_strobes",   {30'h0, WRITE, READ}, 32'h0);
      chk("q_hreadyout", {31'h0, HREADYOUT},   32'h1);
      chk("q_hresp",     {31'h0, HRESP},       32'h0);
      chk("q_hrdata",    HRDATA,               32'h0);
      chk("q_wr_data",   WR_DATA,              32'h0);
    end
    go_idle();
    tick();

    // ---------------- reset mid-read ----------------
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'b010);
    tick();
    go_idle();
    #1;
    chk("mr_read_before", {31'h0, READ}, 32'h1);
    RST = 1'b0;
    #1;
    chk("mr_read",      {31'h0, READ},      32'h0);
    chk("mr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("mr_hrdata",    HRDATA,             32'h0);
    chk("mr_rd_addr",   RD_ADDR,            32'h0);
    chk("mr_wr_addr",   WR_ADDR,            32'h0);
    tick();
    tick();
    RST = 1'b1;
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'b010);
    tick();
    go_idle();
    #1;
    chk("mr2_rd_addr", RD_ADDR, 32'h4);
    tick();
    chk("mr2_hrdata",  HRDATA,  32'hDEAD_BEEF);
    tick();

    // ---------------- top-of-window word ----------------
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'hFFC, 3'b010);
    tick();
    HWDATA = 32'hCAFE_F00D;
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'hFFC, 3'b010);
    #1;
    chk("top_write",   {31'h0, WRITE}, 32'h1);
    chk("top_wr_addr", WR_ADDR,        32'd1023);
    chk("top_wr_resp", {31'h0, HRESP}, 32'h0);
    tick();
    go_idle();
    #1;
    chk("top_read",    {31'h0, READ},  32'h1);
    chk("top_rd_addr", RD_ADDR,        32'd1023);
    tick();
    chk("top_hrdata",  HRDATA,         32'hCAFE_F00D);
    chk("top_rd_resp", {31'h0, HRESP}, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
